in_port_fifo: RTL and testbench

- Input-port reader for the 4-bit CPU. It is the consumer-side counterpart of the load-enabled nibble register.
- An external device writes 4-bit nibbles through a valid/ready handshake. The CPU's IN path pops them in order.
- A small circular FIFO decouples device timing from pipeline timing.
- Status outputs (count, overflow) are available for polling.

---
 rtl/in_port_fifo.sv | 90 +++++++++
 tb/tb_in_port_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/in_port_fifo.sv
// in_port_fifo: input-port reader for the 4-bit CPU.
// A device pushes nibbles through a valid/ready handshake into a small circular
// FIFO. The CPU IN path pops them in order with first-word fall-through.
// Count and a sticky overflow flag are exposed for polling.
module in_port_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4,   // power of two, at least 2
   parameter int unsigned AW    = 2    // log2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ext_valid,
   input  logic [WIDTH-1:0] ext_data,
   output logic             ext_ready,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [AW:0]      count,
   output logic             ovf,
   input  logic             ovf_clr
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             full;
   logic             empty;
   logic             wr_fire;
   logic             rd_fire;

   // Status and handshake terms, all decoded from registered state.
   always_comb begin
      full      = (count == FULL_COUNT);
      empty     = (count == '0);
      ext_ready = !full && !reset;
      rd_valid  = !empty;
      rd_data   = rd_valid ? mem[rptr] : '0;
      wr_fire   = ext_valid && ext_ready;
      rd_fire   = rd_en && rd_valid && !reset;
   end

   // Storage array; not reset, written only on an accepted handshake.
   always_ff @(posedge clock) begin
      if (wr_fire) begin
         mem[wptr] <= ext_data;
      end
   end

   // Write and read pointers wrap naturally at DEPTH.
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_fire) begin
            wptr <= wptr + AW'(1);
         end
         if (rd_fire) begin
            rptr <= rptr + AW'(1);
         end
      end
   end

   // Occupancy: moves only when exactly one of write/read fires.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow: a strobe while full sets it, and set beats clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (ext_valid && full) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_in_port_fifo.sv
// Self-checking bench for in_port_fifo: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_in_port_fifo;

   logic       clock;
   logic       reset;
   logic       ext_valid;
   logic [3:0] ext_data;
   logic       ext_ready;
   logic       rd_en;
   logic [3:0] rd_data;
   logic       rd_valid;
   logic [2:0] count;
   logic       ovf;
   logic       ovf_clr;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: an ordered queue of stored nibbles and a sticky flag.
   logic [3:0] q[$];
   bit         m_ovf;

   in_port_fifo #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .ext_valid(ext_valid),
      .ext_data (ext_data),
      .ext_ready(ext_ready),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic       exp_ready(); return q.size() != 4; endfunction
   function automatic logic       exp_valid(); return q.size() != 0; endfunction
   function automatic logic [3:0] exp_data();  return (q.size() != 0) ? q[0] : 4'h0; endfunction
   function automatic logic [2:0] exp_count(); return 3'(q.size()); endfunction

   task automatic model_step(input bit v, input logic [3:0] d, input bit r, input bit c, input bit rst);
      bit full;
      bit do_wr;
      bit do_rd;
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         full  = (q.size() == 4);
         do_wr = v && !full;
         do_rd = r && (q.size() != 0);
         if (v && full) m_ovf = 1'b1;
         else if (c)    m_ovf = 1'b0;
         if (do_rd) void'(q.pop_front());
         if (do_wr) q.push_back(d);
      end
   endtask

   // One clock: apply inputs, take the edge, return inputs to idle.
   task automatic tick(input bit v, input logic [3:0] d, input bit r, input bit c, input bit rst);
      ext_valid = v; ext_data = d; rd_en = r; ovf_clr = c; reset = rst;
      @(posedge clock);
      model_step(v, d, r, c, rst);
      @(negedge clock);
      ext_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      n_checks++;
      if (ext_ready !== 1'b0) $display("FAIL reset_ready_during got=%b exp=0", ext_ready);
      else n_pass++;
      tick(0, 4'h0, 0, 0, 1);
      n_checks++;
      if (ext_ready !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 4'h0 || count !== 3'd0 || ovf !== 1'b0)
         $display("FAIL reset_state got ready=%b valid=%b data=%h count=%0d ovf=%b exp 1 0 0 0 0",
                  ext_ready, rd_valid, rd_data, count, ovf);
      else n_pass++;
      tick(1, 4'h2, 0, 0, 0);
      tick(1, 4'h9, 0, 0, 0);
      n_checks++;
      if (count !== exp_count()) $display("FAIL reset_pre_count got=%0d exp=%0d", count, exp_count());
      else n_pass++;
      tick(1, 4'h4, 1, 0, 1);
      n_checks++;
      if (count !== 3'd0 || rd_valid !== 1'b0 || count !== exp_count())
         $display("FAIL reset_mid got count=%0d valid=%b exp count=0 valid=0", count, rd_valid);
      else n_pass++;
   endtask

   task automatic test_fill_drain();
      logic [3:0] vals [4];
      vals = '{4'h3, 4'hA, 4'h5, 4'hF};
      for (int i = 0; i < 4; i++) tick(1, vals[i], 0, 0, 0);
      n_checks++;
      if (count !== 3'd4 || ext_ready !== 1'b0 || count !== exp_count())
         $display("FAIL fill_full got count=%0d ready=%b exp count=4 ready=0", count, ext_ready);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rd_data !== vals[i] || rd_valid !== 1'b1 || rd_data !== exp_data())
            $display("FAIL drain_data idx=%0d got=%h exp=%h", i, rd_data, vals[i]);
         else n_pass++;
         tick(0, 4'h0, 1, 0, 0);
      end
      n_checks++;
      if (rd_valid !== 1'b0 || count !== 3'd0 || rd_data !== 4'h0)
         $display("FAIL drain_empty got valid=%b count=%0d data=%h exp 0 0 0", rd_valid, count, rd_data);
      else n_pass++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) tick(1, 4'($urandom_range(15)), 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 4'h0, 1, 0, 0);
      for (int i = 1; i <= 4; i++) tick(1, 4'(i), 0, 0, 0);
      n_checks++;
      if (count !== 3'd4) $display("FAIL wrap_count got=%0d exp=4", count);
      else n_pass++;
      for (int i = 1; i <= 4; i++) begin
         n_checks++;
         if (rd_data !== 4'(i) || rd_data !== exp_data())
            $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, rd_data, 4'(i));
         else n_pass++;
         tick(0, 4'h0, 1, 0, 0);
      end
      n_checks++;
      if (count !== 3'd0 || rd_valid !== 1'b0) $display("FAIL wrap_end got count=%0d valid=%b exp 0 0", count, rd_valid);
      else n_pass++;
   endtask

   task automatic test_full_simultaneous();
      logic [3:0] order [4];
      order = '{4'h7, 4'h8, 4'h9, 4'hC};
      tick(1, 4'h6, 0, 0, 0);
      tick(1, 4'h7, 0, 0, 0);
      tick(1, 4'h8, 0, 0, 0);
      tick(1, 4'h9, 0, 0, 0);
      n_checks++;
      if (rd_data !== 4'h6) $display("FAIL full_sim_head got=%h exp=6", rd_data);
      else n_pass++;
      tick(1, 4'hC, 1, 0, 0);
      n_checks++;
      if (count !== 3'd3 || rd_data !== 4'h7 || ovf !== m_ovf)
         $display("FAIL full_sim_pop got count=%0d data=%h ovf=%b exp count=3 data=7 ovf=%b", count, rd_data, ovf, m_ovf);
      else n_pass++;
      tick(1, 4'hC, 0, 0, 0);
      n_checks++;
      if (count !== 3'd4) $display("FAIL full_sim_retry got=%0d exp=4", count);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rd_data !== order[i] || rd_data !== exp_data())
            $display("FAIL full_sim_order idx=%0d got=%h exp=%h", i, rd_data, order[i]);
         else n_pass++;
         tick(0, 4'h0, 1, 0, 0);
      end
      tick(0, 4'h0, 0, 1, 0);
      n_checks++;
      if (ovf !== 1'b0) $display("FAIL full_sim_clr got=%b exp=0", ovf);
      else n_pass++;
   endtask

   task automatic test_empty_read();
      tick(0, 4'h0, 1, 0, 0);
      n_checks++;
      if (count !== 3'd0 || rd_valid !== 1'b0 || ovf !== 1'b0)
         $display("FAIL empty_read got count=%0d valid=%b ovf=%b exp 0 0 0", count, rd_valid, ovf);
      else n_pass++;
      tick(1, 4'hB, 1, 0, 0);
      n_checks++;
      if (count !== 3'd1 || rd_data !== 4'hB || rd_valid !== 1'b1)
         $display("FAIL empty_wr_rd got count=%0d data=%h valid=%b exp 1 b 1", count, rd_data, rd_valid);
      else n_pass++;
      tick(0, 4'h0, 1, 0, 0);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) tick(1, 4'(i + 8), 0, 0, 0);
      tick(1, 4'hE, 0, 0, 0);
      n_checks++;
      if (ovf !== 1'b1 || count !== 3'd4) $display("FAIL ovf_set got ovf=%b count=%0d exp 1 4", ovf, count);
      else n_pass++;
      tick(1, 4'hD, 0, 1, 0);
      n_checks++;
      if (ovf !== 1'b1) $display("FAIL ovf_set_wins got=%b exp=1", ovf);
      else n_pass++;
      tick(0, 4'h0, 0, 1, 0);
      n_checks++;
      if (ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rd_data !== 4'(i + 8)) $display("FAIL ovf_not_stored idx=%0d got=%h exp=%h", i, rd_data, 4'(i + 8));
         else n_pass++;
         tick(0, 4'h0, 1, 0, 0);
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick(($urandom_range(99) < 55), 4'($urandom_range(15)), ($urandom_range(99) < 45),
              ($urandom_range(99) < 8), ($urandom_range(199) == 0));
         n_checks++;
         if (ext_ready !== exp_ready()) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, ext_ready, exp_ready());
         else n_pass++;
         n_checks++;
         if (rd_valid !== exp_valid()) $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, exp_valid());
         else n_pass++;
         n_checks++;
         if (rd_data !== exp_data()) $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, rd_data, exp_data());
         else n_pass++;
         n_checks++;
         if (count !== exp_count()) $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, exp_count());
         else n_pass++;
         n_checks++;
         if (ovf !== m_ovf) $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, ovf, m_ovf);
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1; ext_valid = 1'b0; ext_data = 4'h0; rd_en = 1'b0; ovf_clr = 1'b0;
      m_ovf = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      test_reset();
      test_fill_drain();
      test_wrap();
      test_full_simultaneous();
      test_empty_read();
      test_overflow();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
